// File: rtl/xbus_arbiter_pkg.sv
// Shared definitions for the XBUS arbiter: transaction states, byte-mask
// encodings and the default physical address width.
package xbus_arbiter_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_A2,
        S_A1,
        S_A0,
        S_D0,
        S_D1,
        S_FIN
    } xbus_state_t;

    localparam logic [1:0] MASK_NONE = 2'b00;
    localparam logic [1:0] MASK_LO   = 2'b01;
    localparam logic [1:0] MASK_HI   = 2'b10;
    localparam logic [1:0] MASK_WORD = 2'b11;

    localparam int unsigned PA_DEFAULT = 22;

endpackage

// File: rtl/xbus_arbiter_rr_pick.sv
// Round-robin selector: first requester at or after ptr (wrapping) wins.
module xbus_rr_pick #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant
);

    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (!found && req[i] && (i == (32'(ptr) + k) % NREQ)) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/xbus_arbiter.sv
// Multi-requester XBUS master: arbitrates, then sequences address latches
// and byte-wide data transfers on the shared external bus.
module xbus_arbiter
    import xbus_arbiter_pkg::*;
#(
    parameter int unsigned PA   = PA_DEFAULT,
    parameter int unsigned NREQ = 3
) (
    input  logic                     clk,
    input  logic                     r_reset,
    input  logic                     ena,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [2*NREQ-1:0]        req_rmask,
    input  logic [2*NREQ-1:0]        req_wmask,
    input  logic [NREQ*(PA-1)-1:0]   req_addr,
    input  logic [16*NREQ-1:0]       req_wdata,
    output logic [NREQ-1:0]          done,
    output logic [15:0]              rdata,
    output logic [7:0]               bus_out,
    input  logic [7:0]               bus_in,
    output logic                     latch_hi,
    output logic                     latch_lo,
    output logic                     bus_write,
    output logic                     bus_ind
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    xbus_state_t      state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic [NREQ-1:0]  done_q, done_d;
    logic             is_write_q, is_write_d;
    logic [1:0]       mask_q, mask_d;
    logic [PA-1:1]    addr_q, addr_d;
    logic [15:0]      wdata_q, wdata_d;
    logic [15:0]      rdata_q, rdata_d;
    logic [7:0]       bus_out_q, bus_out_d;
    logic             latch_hi_q, latch_hi_d;
    logic             latch_lo_q, latch_lo_d;
    logic             bus_write_q, bus_write_d;
    logic             bus_ind_q, bus_ind_d;

    logic [NREQ-1:0]  pick;
    logic [PW-1:0]    pick_idx;
    logic [1:0]       pick_rmask, pick_wmask, pick_mask;
    logic [PA-1:1]    pick_addr;
    logic [15:0]      pick_wdata;
    logic [15:0]      cur_lo;

    xbus_rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (pick)
    );

    always_comb begin
        pick_idx   = '0;
        pick_rmask = '0;
        pick_wmask = '0;
        pick_addr  = '0;
        pick_wdata = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick[i]) begin
                pick_idx   = PW'(i);
                pick_rmask = req_rmask[2*i +: 2];
                pick_wmask = req_wmask[2*i +: 2];
                pick_addr  = req_addr[(PA-1)*i +: (PA-1)];
                pick_wdata = req_wdata[16*i +: 16];
            end
        end
        pick_mask = (pick_wmask != MASK_NONE) ? pick_wmask : pick_rmask;
    end

    assign cur_lo = {addr_q[15:1], 1'b0};

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        done_d      = done_q;
        is_write_d  = is_write_q;
        mask_d      = mask_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        bus_out_d   = bus_out_q;
        latch_hi_d  = latch_hi_q;
        latch_lo_d  = latch_lo_q;
        bus_write_d = bus_write_q;
        bus_ind_d   = bus_ind_q;
        if (ena) begin
            case (state_q)
                S_IDLE: begin
                    latch_hi_d  = 1'b0;
                    latch_lo_d  = 1'b0;
                    bus_write_d = 1'b0;
                    bus_ind_d   = 1'b0;
                    done_d      = '0;
                    if (|req_valid) begin
                        grant_d    = pick;
                        ptr_d      = (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
                        is_write_d = (pick_wmask != MASK_NONE);
                        mask_d     = pick_mask;
                        addr_d     = pick_addr;
                        wdata_d    = pick_wdata;
                        // A request with no byte lanes completes without touching the bus
                        if (pick_mask == MASK_NONE) begin
                            done_d  = pick;
                            state_d = S_FIN;
                        end else begin
                            bus_out_d  = 8'(pick_addr[PA-1:16]);
                            latch_hi_d = 1'b1;
                            state_d    = S_A2;
                        end
                    end
                end
                S_A2: begin
                    bus_out_d  = cur_lo[15:8];
                    latch_hi_d = 1'b1;
                    latch_lo_d = 1'b1;
                    state_d    = S_A1;
                end
                S_A1: begin
                    bus_out_d  = cur_lo[7:0];
                    latch_hi_d = 1'b0;
                    latch_lo_d = 1'b1;
                    bus_ind_d  = (mask_q == MASK_HI);
                    state_d    = S_A0;
                end
                S_A0: begin
                    latch_lo_d = 1'b0;
                    if (is_write_q) begin
                        bus_out_d   = (mask_q == MASK_HI) ? wdata_q[15:8] : wdata_q[7:0];
                        bus_write_d = 1'b1;
                        if (mask_q == MASK_WORD) begin
                            state_d = S_D1;
                        end else begin
                            done_d  = grant_q;
                            state_d = S_FIN;
                        end
                    end else begin
                        state_d = S_D0;
                    end
                end
                S_D0: begin
                    if (mask_q == MASK_HI) rdata_d[15:8] = bus_in;
                    else                   rdata_d[7:0]  = bus_in;
                    if (mask_q == MASK_WORD) begin
                        bus_ind_d = 1'b1;
                        state_d   = S_D1;
                    end else begin
                        done_d  = grant_q;
                        state_d = S_FIN;
                    end
                end
                S_D1: begin
                    if (is_write_q) begin
                        bus_out_d   = wdata_q[15:8];
                        bus_ind_d   = 1'b1;
                        bus_write_d = 1'b1;
                    end else begin
                        rdata_d[15:8] = bus_in;
                    end
                    done_d  = grant_q;
                    state_d = S_FIN;
                end
                S_FIN: begin
                    done_d      = '0;
                    bus_write_d = 1'b0;
                    bus_ind_d   = 1'b0;
                    state_d     = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            done_q      <= '0;
            is_write_q  <= 1'b0;
            mask_q      <= MASK_NONE;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            bus_out_q   <= '0;
            latch_hi_q  <= 1'b0;
            latch_lo_q  <= 1'b0;
            bus_write_q <= 1'b0;
            bus_ind_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            is_write_q  <= is_write_d;
            mask_q      <= mask_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            bus_out_q   <= bus_out_d;
            latch_hi_q  <= latch_hi_d;
            latch_lo_q  <= latch_lo_d;
            bus_write_q <= bus_write_d;
            bus_ind_q   <= bus_ind_d;
        end
    end

    assign done      = done_q;
    assign rdata     = rdata_q;
    assign bus_out   = bus_out_q;
    assign latch_hi  = latch_hi_q;
    assign latch_lo  = latch_lo_q;
    assign bus_write = bus_write_q;
    assign bus_ind   = bus_ind_q;

endmodule

// File: tb/tb_xbus_arbiter.sv
// Scoreboarded bench for xbus_arbiter: completions are matched against
// expectations queued when each request is issued.
module tb_xbus_arbiter;

    localparam int unsigned PA   = 22;
    localparam int unsigned NREQ = 3;
    localparam int unsigned AW   = PA - 1;

    localparam logic [7:0] WW_BUS [0:4] = '{8'h3A, 8'hBC, 8'hDE, 8'h34, 8'h12};
    localparam logic [2:0] WW_STB [0:4] = '{3'b100, 3'b110, 3'b010, 3'b001, 3'b001};

    logic                   clk = 1'b0;
    logic                   r_reset;
    logic                   ena;
    logic [NREQ-1:0]        req_valid;
    logic [2*NREQ-1:0]      req_rmask;
    logic [2*NREQ-1:0]      req_wmask;
    logic [NREQ*AW-1:0]     req_addr;
    logic [16*NREQ-1:0]     req_wdata;
    logic [NREQ-1:0]        done;
    logic [15:0]            rdata;
    logic [7:0]             bus_out;
    logic [7:0]             bus_in;
    logic                   latch_hi, latch_lo, bus_write, bus_ind;

    logic [7:0]             rd_lo, rd_hi;

    // External memory stand-in: bus_ind selects which byte it returns
    assign bus_in = bus_ind ? rd_hi : rd_lo;

    xbus_arbiter #(
        .PA   (PA),
        .NREQ (NREQ)
    ) dut (
        .clk       (clk),
        .r_reset   (r_reset),
        .ena       (ena),
        .req_valid (req_valid),
        .req_rmask (req_rmask),
        .req_wmask (req_wmask),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .done      (done),
        .rdata     (rdata),
        .bus_out   (bus_out),
        .bus_in    (bus_in),
        .latch_hi  (latch_hi),
        .latch_lo  (latch_lo),
        .bus_write (bus_write),
        .bus_ind   (bus_ind)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned idx;
        bit          is_read;
        logic [15:0] rdata;
        int unsigned lat;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_err    = 0;
    int unsigned cyc      = 0;
    int unsigned start_cyc = 0;
    logic        latch_hi_prev = 1'b0;
    logic [15:0] model_rd = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (latch_hi && !latch_hi_prev) start_cyc <= cyc;
        latch_hi_prev <= latch_hi;
        if (done != '0) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_done", 32'(done), 32'h0);
            end else begin
                e = sb.pop_front();
                check_eq("done_idx", 32'(done), 32'h1 << e.idx);
                if (e.lat != 0) check_eq("latency", cyc - start_cyc + 1, e.lat);
                if (e.is_read) check_eq("rdata", 32'(rdata), 32'(e.rdata));
            end
        end
    end

    task automatic set_req(input int unsigned i, input logic [1:0] rm, input logic [1:0] wm,
                           input logic [PA-1:0] ba, input logic [15:0] wd);
        req_rmask[2*i +: 2]  = rm;
        req_wmask[2*i +: 2]  = wm;
        req_addr[AW*i +: AW] = ba[PA-1:1];
        req_wdata[16*i +: 16] = wd;
        req_valid[i]         = 1'b1;
    endtask

    task automatic expect_txn(input int unsigned i, input logic [1:0] rm, input logic [1:0] wm,
                              input int unsigned lat);
        exp_t e;
        e.idx     = i;
        e.lat     = lat;
        e.is_read = (wm == 2'b00) && (rm != 2'b00);
        if (e.is_read) begin
            if (rm == 2'b10) model_rd[15:8] = rd_hi;
            else             model_rd[7:0]  = rd_lo;
            if (rm == 2'b11) model_rd[15:8] = rd_hi;
        end
        e.rdata = model_rd;
        sb.push_back(e);
    endtask

    task automatic wait_done(output int unsigned idx);
        idx = NREQ;
        for (int unsigned k = 0; k < 64; k++) begin
            @(negedge clk);
            if (done != '0) begin
                for (int unsigned j = 0; j < NREQ; j++) if (done[j]) idx = j;
                return;
            end
        end
        check_eq("done_timeout", {31'd0, |done}, 32'd1);
    endtask

    initial begin : stim
        int unsigned idx;
        logic [30:0] snap;
        r_reset   = 1'b1;
        ena       = 1'b1;
        req_valid = '0;
        req_rmask = '0;
        req_wmask = '0;
        req_addr  = '0;
        req_wdata = '0;
        rd_lo     = '0;
        rd_hi     = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_bus_out", 32'(bus_out), 32'h0);
        check_eq("rst_strobes", {28'd0, latch_hi, latch_lo, bus_write, bus_ind}, 32'h0);
        check_eq("rst_done", 32'(done), 32'h0);
        check_eq("rst_rdata", 32'(rdata), 32'h0);
        r_reset = 1'b0;

        // Round robin from reset: 0, 1, 2, then 0 again
        rd_lo = 8'h5A;
        rd_hi = 8'hA5;
        set_req(0, 2'b00, 2'b01, 22'h000100, 16'h00C3);
        set_req(1, 2'b01, 2'b00, 22'h000200, 16'h0000);
        set_req(2, 2'b10, 2'b00, 22'h000300, 16'h0000);
        expect_txn(0, 2'b00, 2'b01, 4);
        expect_txn(1, 2'b01, 2'b00, 5);
        expect_txn(2, 2'b10, 2'b00, 5);
        expect_txn(0, 2'b00, 2'b11, 5);
        for (int n = 0; n < 4; n++) begin
            wait_done(idx);
            if (n == 0 && idx == 0) set_req(0, 2'b00, 2'b11, 22'h000400, 16'hBEEF);
            else if (idx < NREQ)    req_valid[idx] = 1'b0;
        end
        @(negedge clk);

        // Word write with request inputs scrambled after grant
        set_req(0, 2'b00, 2'b11, 22'h3ABCDE, 16'h1234);
        expect_txn(0, 2'b00, 2'b11, 5);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq("ww_bus_out", 32'(bus_out), 32'(WW_BUS[k]));
            check_eq("ww_strobes", {29'd0, latch_hi, latch_lo, bus_write}, 32'(WW_STB[k]));
            if (k == 0) begin
                req_wdata[15:0] = 16'hFFFF;
                req_addr[AW-1:0] = '1;
            end
        end
        check_eq("ww_done", 32'(done), 32'h1);
        req_valid[0] = 1'b0;
        @(negedge clk);

        // Word read by requester 1
        rd_lo = 8'h55;
        rd_hi = 8'hAA;
        set_req(1, 2'b11, 2'b00, 22'h001000, 16'h0000);
        expect_txn(1, 2'b11, 2'b00, 6);
        wait_done(idx);
        check_eq("wr_rdata", 32'(rdata), 32'hAA55);
        req_valid[1] = 1'b0;
        @(negedge clk);

        // High-byte-only write
        set_req(2, 2'b00, 2'b10, 22'h012346, 16'h9900);
        expect_txn(2, 2'b00, 2'b10, 4);
        @(negedge clk);
        check_eq("hb_addr2", 32'(bus_out), 32'h01);
        @(negedge clk);
        check_eq("hb_addr1", 32'(bus_out), 32'h23);
        @(negedge clk);
        check_eq("hb_addr0", 32'(bus_out), 32'h46);
        check_eq("hb_ind_a0", 32'(bus_ind), 32'h1);
        @(negedge clk);
        check_eq("hb_data", 32'(bus_out), 32'h99);
        check_eq("hb_wr_ind", {30'd0, bus_write, bus_ind}, 32'h3);
        check_eq("hb_done", 32'(done), 32'h4);
        req_valid[2] = 1'b0;
        @(negedge clk);
        check_eq("fin_clear", {27'd0, done, bus_write, bus_ind}, 32'h0);
        check_eq("rdata_hold", 32'(rdata), 32'hAA55);

        // Empty-mask request: immediate done, no strobes
        set_req(1, 2'b00, 2'b00, 22'h002000, 16'h0000);
        expect_txn(1, 2'b00, 2'b00, 0);
        @(negedge clk);
        check_eq("nomask_done", 32'(done), 32'h2);
        check_eq("nomask_strobes", {28'd0, latch_hi, latch_lo, bus_write, bus_ind}, 32'h0);
        req_valid[1] = 1'b0;
        @(negedge clk);

        // ena dropped for three cycles during D0 of a word read
        rd_lo = 8'h11;
        rd_hi = 8'h22;
        set_req(1, 2'b11, 2'b00, 22'h004000, 16'h0000);
        expect_txn(1, 2'b11, 2'b00, 9);
        repeat (4) @(negedge clk);
        ena  = 1'b0;
        snap = {bus_out, latch_hi, latch_lo, bus_write, bus_ind, done, rdata};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("ena_freeze", 32'({bus_out, latch_hi, latch_lo, bus_write, bus_ind, done, rdata}),
                     32'(snap));
        end
        ena = 1'b1;
        wait_done(idx);
        req_valid[1] = 1'b0;
        @(negedge clk);

        // Reset while in A1 abandons the transaction
        set_req(0, 2'b00, 2'b11, 22'h005000, 16'hCAFE);
        repeat (2) @(negedge clk);
        r_reset   = 1'b1;
        req_valid = '0;
        @(negedge clk);
        check_eq("abort_bus_out", 32'(bus_out), 32'h0);
        check_eq("abort_strobes", {28'd0, latch_hi, latch_lo, bus_write, bus_ind}, 32'h0);
        check_eq("abort_rdata", 32'(rdata), 32'h0);
        r_reset  = 1'b0;
        model_rd = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check_eq("abort_no_done", 32'(done), 32'h0);
        end

        check_eq("sb_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/xbus_arbiter.md
XBUS_ARBITER -- requirements
Module: xbus_arbiter

Interface
REQ-001 Parameter PA, default 22: physical address width in bits; the address port is PA-1:1, addressing 16-bit words.
REQ-002 Parameter NREQ, default 3: number of requesters; port i in 0..NREQ-1.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 r_reset  input  1  reset; synchronous, active-high.
REQ-005 ena  input  1  global enable; low freezes all state and holds all outputs.
REQ-006 req_valid  input  NREQ  per-requester request; held high until done.
REQ-007 req_rmask  input  2*NREQ  per-requester read byte mask: 01 low byte, 10 high byte, 11 both, 00 not a read.
REQ-008 req_wmask  input  2*NREQ  per-requester write byte mask, same encoding; nonzero means write, and overrides rmask.
REQ-009 req_addr  input  NREQ*(PA-1)  per-requester word address.
REQ-010 req_wdata  input  16*NREQ  per-requester write data.
REQ-011 done  output  NREQ  one-cycle completion pulse to the granted requester.
REQ-012 rdata  output  16  read data; valid in the cycle done is high.
REQ-013 bus_out  output  8  byte driven to the external address latches / data bus.
REQ-014 bus_in  input  8  external read data byte.
REQ-015 latch_hi, latch_lo, bus_write, bus_ind  output  1 each  external latch strobes, write strobe, and high-byte indicator.

Function
REQ-016 States: IDLE, A2, A1, A0, D0, D1, FIN.
- IDLE: if any requester is valid, grant per REQ-017, latch its request into internal registers, drive bus_out = addr[PA-1:16] with latch_hi = 1, and go to A2.
REQ-017 Arbitration is round-robin: search starts at the index after the last granted requester; after reset the search starts at index 0.
REQ-018 A2: bus_out = addr[15:8], latch_hi = 1, latch_lo = 1, go to A1.
REQ-019 A1: bus_out = {addr[7:1], 0}, latch_hi = 0, latch_lo = 1, go to A0.
- A1 also sets bus_ind = 1 if the first byte is the high byte (mask 10), otherwise bus_ind = 0.
REQ-020 A0, write: bus_out = first-byte data, latch_lo = 0, bus_write = 1.
- Go to D1 if mask = 11, otherwise go to FIN with done asserted.
REQ-021 A0, read: latch_lo = 0, go to D0.
REQ-022 D0, read: capture bus_in into rdata[7:0] (mask 01 or 11) or rdata[15:8] (mask 10).
- If mask = 11, set bus_ind = 1 and go to D1; otherwise go to FIN with done asserted.
REQ-023 D1, write: bus_out = wdata[15:8], bus_ind = 1, bus_write = 1, done asserted, go to FIN.
- D1, read: capture bus_in into rdata[15:8], done asserted, go to FIN.
REQ-024 FIN: clear done, bus_write and bus_ind; go to IDLE; no new grant is issued in FIN.
REQ-025 Latency from IDLE grant to done: 4 cycles for a single-byte write, 5 for a word write or single-byte read, 6 for a word read.
REQ-026 done is exactly one cycle wide and is driven only to the granted index.
REQ-027 rdata holds its value until the next read capture.
REQ-028 Request inputs are sampled only in IDLE; changes during a transaction are ignored and the transaction completes.
REQ-029 A requester with valid high but both masks 00 is granted, completes immediately through FIN with done, and drives no bus strobes.
REQ-030 With ena low, the state, registers and outputs hold; the sequence resumes on the next cycle ena is high.

Reset
REQ-031 With r_reset high, the next state is IDLE; latch_hi, latch_lo, bus_write, bus_ind and done are 0; bus_out is 0; rdata is 0; the round-robin pointer points so index 0 wins next.
REQ-032 Reset mid-transaction abandons the transaction with no done pulse; the requester re-issues it.

Structure
REQ-033 A shared package holds the state enumeration, the byte-mask encodings and the PA default.
REQ-034 Round-robin selection is one sub-module, xbus_rr_pick (NREQ-wide request vector plus pointer in; one-hot grant out).

Verification
REQ-035 Req0 word write, addr 0x3ABCDE, wdata 0x1234:
- bus_out sequence 0x3A, 0xBC, 0xDE, 0x34, 0x12.
- bus_write high on the last two of these cycles.
- done[0] in the cycle after the 0x34 cycle (the 0x12 cycle).
REQ-036 Req1 word read with bus_in 0x55 then 0xAA: rdata = 0xAA55 with done[1] 6 cycles after grant.
REQ-037 All three requesters valid from reset: grants occur in order 0, 1, 2, 0, each taking the latency given in REQ-025.
REQ-038 High-byte-only write, wmask 10, wdata 0x9900:
- bus_ind = 1 in the data cycle and bus_out = 0x99.
- done after 4 cycles.
REQ-039 r_reset asserted in state A1: the next cycle is IDLE with all strobes 0 and no done pulse.
REQ-040 ena dropped for 3 cycles during D0: outputs are frozen, and the transaction completes with latency extended by 3 cycles.
